// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Stall vectors are ordered 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
package pipeline_ctrl_pkg;

   localparam int STALL_VEC_W = 6;
   localparam int STAGE_PC    = 0;
   localparam int STAGE_EX    = 3;

   typedef logic [STALL_VEC_W-1:0] stall_vec_t;

   localparam stall_vec_t STALL_NONE = 6'b000000;
   localparam stall_vec_t STALL_IF   = 6'b000011;
   localparam stall_vec_t STALL_ID   = 6'b000111;
   localparam stall_vec_t STALL_EX   = 6'b001111;
   localparam stall_vec_t STALL_MEM  = 6'b011111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FWAIT = 1'b1
   } state_t;

   // Deepest requesting stage wins; WB is never stopped.
   function automatic stall_vec_t encode_stall(input logic req_mem, input logic req_ex,
                                               input logic req_id, input logic req_if);
      if (req_mem)     return STALL_MEM;
      else if (req_ex) return STALL_EX;
      else if (req_id) return STALL_ID;
      else if (req_if) return STALL_IF;
      else             return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipeline_ctrl_stall_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (en && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: priority-encodes stage stall requests, sequences
// taken-branch flush/redirect (deferred behind a busy fetch) and keeps counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int STALL_W = STALL_VEC_W,
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 32,
   parameter int FCNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              stallreq_mem,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [STALL_W-1:0] stall,
   output logic              flush,
   output logic              if_discard,
   output logic              pc_load,
   output logic [ADDR_W-1:0] new_pc,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [FCNT_W-1:0] flush_cnt
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
   stall_vec_t        req_vec, stall_vec;
   logic              upstream_busy;

   assign req_vec       = encode_stall(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
   assign upstream_busy = stallreq_mem | stallreq_ex | stallreq_id;
   assign stall         = STALL_W'(stall_vec);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      stall_vec   = req_vec;
      flush       = 1'b0;
      if_discard  = 1'b0;
      pc_load     = 1'b0;
      new_pc      = '0;
      state_nxt   = state;
      pend_pc_nxt = pend_pc;

      if (rst) begin
         stall_vec = STALL_NONE;
      end else begin
         unique case (state)
            ST_RUN: begin
               // A frozen EX re-presents the branch later, so act only when EX advances.
               if (branch_flag && !req_vec[STAGE_EX]) begin
                  flush = 1'b1;
                  if (!stallreq_if) begin
                     pc_load = 1'b1;
                     new_pc  = branch_target;
                  end else begin
                     pend_pc_nxt = branch_target;
                     state_nxt   = ST_FWAIT;
                  end
               end
            end
            ST_FWAIT: begin
               stall_vec  = req_vec | STALL_IF;
               if_discard = 1'b1;
               if (!stallreq_if && !upstream_busy) begin
                  pc_load   = 1'b1;
                  new_pc    = pend_pc;
                  state_nxt = ST_RUN;
               end
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   // NOTE: pend_pc is a single control register, not storage, so it is reset with the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         pend_pc   <= '0;
         flush_cnt <= '0;
      end else begin
         state   <= state_nxt;
         pend_pc <= pend_pc_nxt;
         if (flush)
            flush_cnt <= flush_cnt + FCNT_W'(1);
      end
   end

   pipeline_ctrl_stall_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_vec[STAGE_PC]),
      .count (stall_cnt)
   );

   // EX holds a bubble while a redirect waits on fetch, so no branch can resolve.
   a_no_branch_in_fwait : assert property (@(posedge clk) disable iff (rst)
      (state == ST_FWAIT) |-> !branch_flag);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the stall/redirect rules; small counters expose wrap/saturation.
module tb_pipeline_ctrl;

   localparam int ADDR_W  = 32;
   localparam int CNT_W   = 6;
   localparam int FCNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int FCNT_MOD = 1 << FCNT_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic              branch_flag;
   logic [ADDR_W-1:0] branch_target;
   logic [5:0]        stall;
   logic              flush, if_discard, pc_load;
   logic [ADDR_W-1:0] new_pc;
   logic [CNT_W-1:0]  stall_cnt;
   logic [FCNT_W-1:0] flush_cnt;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // Model state: is a redirect waiting on fetch, and the counts seen so far.
   bit          m_pending;
   logic [31:0] m_pend_pc;
   int          m_stall_cnt;
   int          m_flush_cnt;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .STALL_W (6),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W),
      .FCNT_W  (FCNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_if   (stallreq_if),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .stallreq_mem  (stallreq_mem),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .stall         (stall),
      .flush         (flush),
      .if_discard    (if_discard),
      .pc_load       (pc_load),
      .new_pc        (new_pc),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cycle, actual, expected);
      end
   endtask

   // One clock: drive at negedge, compare combinational outputs, advance the model.
   task automatic step(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                       input bit i_mem, input bit br, input logic [31:0] tgt);
      logic [5:0]  e_stall;
      bit          e_flush, e_disc, e_load;
      logic [31:0] e_pc;
      @(negedge clk);
      rst = r; stallreq_if = i_if; stallreq_id = i_id; stallreq_ex = i_ex;
      stallreq_mem = i_mem; branch_flag = br; branch_target = tgt;
      #1;
      e_stall = 6'd0; e_flush = 0; e_disc = 0; e_load = 0; e_pc = 32'd0;
      if (!r) begin
         if (i_mem)     e_stall = 6'd31;
         else if (i_ex) e_stall = 6'd15;
         else if (i_id) e_stall = 6'd7;
         else if (i_if) e_stall = 6'd3;
         if (m_pending) begin
            e_stall = e_stall | 6'd3;
            e_disc  = 1;
            if (!i_if && !i_id && !i_ex && !i_mem) begin
               e_load = 1;
               e_pc   = m_pend_pc;
            end
         end else if (br && !i_mem && !i_ex) begin
            e_flush = 1;
            if (!i_if) begin
               e_load = 1;
               e_pc   = tgt;
            end
         end
      end
      check("stall", 64'(stall), 64'(e_stall));
      check("flush", 64'(flush), 64'(e_flush));
      check("if_discard", 64'(if_discard), 64'(e_disc));
      check("pc_load", 64'(pc_load), 64'(e_load));
      check("new_pc", 64'(new_pc), 64'(e_pc));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
      check("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
      if (r) begin
         m_pending = 0; m_pend_pc = 32'd0; m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
         if (e_stall[0] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
         if (e_flush) m_flush_cnt = (m_flush_cnt + 1) % FCNT_MOD;
         if (m_pending && e_load) m_pending = 0;
         else if (!m_pending && e_flush && i_if) begin
            m_pending = 1;
            m_pend_pc = tgt;
         end
      end
      cycle++;
   endtask

   initial begin
      rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
      branch_flag = 0; branch_target = '0;
      m_pending = 0; m_pend_pc = '0; m_stall_cnt = 0; m_flush_cnt = 0;

      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF);

      // Enter FWAIT, then reset for 3 cycles with busy inputs: everything clears.
      step(0, 1, 0, 0, 0, 1, 32'h0000_2000);
      step(0, 1, 0, 0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 0, 32'h0);
      check("reset_pending_lost", 64'(m_pending), 64'd0);
      step(0, 0, 0, 0, 0, 0, 32'h0);
      check("post_reset_stall_cnt", 64'(stall_cnt), 64'd0);

      // Priority: mem over if, then if alone.
      step(0, 1, 0, 0, 1, 0, 32'h0);
      check("mem_over_if", 64'(stall), 64'h1F);
      step(0, 1, 0, 0, 0, 0, 32'h0);
      check("if_only", 64'(stall), 64'h03);

      // Immediate redirect.
      step(0, 0, 0, 0, 0, 1, 32'h0000_1040);
      check("redirect_now_pc", 64'(new_pc), 64'h1040);
      step(0, 0, 0, 0, 0, 0, 32'h0);

      // Deferred redirect behind a 3-cycle fetch.
      step(0, 1, 0, 0, 0, 1, 32'h0000_1040);
      step(0, 1, 0, 0, 0, 0, 32'h0);
      check("fwait_discard", 64'(if_discard), 64'd1);
      step(0, 1, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 32'h0);
      check("deferred_pc", 64'(new_pc), 64'h1040);

      // Branch while EX frozen is ignored.
      step(0, 0, 0, 1, 0, 1, 32'h0000_3000);
      check("ex_frozen_noflush", 64'(flush), 64'd0);
      step(0, 0, 0, 0, 0, 0, 32'h0);

      // Saturate stall_cnt, then wrap flush_cnt.
      for (int i = 0; i < CNT_MAX + 5; i++) step(0, 1, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 32'h0);
      check("stall_cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
      for (int i = 0; i < FCNT_MOD; i++) step(0, 0, 0, 0, 0, 1, 32'h100 + 32'(i));
      step(0, 0, 0, 0, 0, 0, 32'h0);
      check("flush_cnt_wrap", 64'(flush_cnt), 64'(m_flush_cnt));

      // Random traffic; branches only when no redirect is pending.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(99) < 2),
              ($urandom_range(99) < 45), ($urandom_range(99) < 15),
              ($urandom_range(99) < 15), ($urandom_range(99) < 12),
              (!m_pending && ($urandom_range(99) < 35)), $urandom());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
